// File: rtl/frame_port_arbiter.sv
// frame_port_arbiter: display-priority arbiter for the frame cell memory with a buffered write FIFO; FB_CLEAR_EN adds a full-frame clear engine
module frame_port_arbiter #(
    parameter int WFIFO_DEPTH  = 4,
    parameter int READ_LATENCY = 1,
    parameter int FRAME_W      = 640,
    parameter int FRAME_H      = 480
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [9:0]                   wr_x,
    input  logic [8:0]                   wr_y,
    input  logic [2:0]                   wr_data,
    input  logic                         disp_req,
    input  logic [9:0]                   disp_x,
    input  logic [8:0]                   disp_y,
    output logic                         disp_rvalid,
    output logic [2:0]                   disp_rdata,
    output logic [9:0]                   mem_x,
    output logic [8:0]                   mem_y,
    output logic                         mem_we,
    output logic [2:0]                   mem_wdata,
    input  logic [2:0]                   mem_rdata,
    output logic [$clog2(WFIFO_DEPTH):0] fifo_level,
    output logic [15:0]                  drop_count,
`ifdef FB_CLEAR_EN
    input  logic                         clear_start,
    output logic                         clear_busy,
`endif
    output logic                         write_stall
);
    localparam int AW = $clog2(WFIFO_DEPTH);
    logic [21:0]             r_fifo [WFIFO_DEPTH];
    logic [AW-1:0]           r_wp, r_rp;
    logic [AW:0]             r_level, w_level_nx;
    logic                    r_wr_ready, r_rvalid, r_mem_we, r_stall;
    logic [2:0]              r_rdata, r_mem_wdata;
    logic [9:0]              r_mem_x, w_clr_x;
    logic [8:0]              r_mem_y, w_clr_y;
    logic [15:0]             r_drop;
    logic [READ_LATENCY-1:0] r_rsh;
    logic                    w_accept, w_in_range, w_push, w_drop, w_pop;
    logic                    w_clear, w_clear_nx, w_clr_wr;
    logic [21:0]             w_head;

    assign w_accept   = wr_valid && r_wr_ready;
    assign w_in_range = 32'(wr_x) < FRAME_W && 32'(wr_y) < FRAME_H;
    assign w_push     = w_accept && w_in_range;
    assign w_drop     = w_accept && !w_in_range;
    assign w_pop      = !disp_req && !w_clear && r_level != '0;
    assign w_clr_wr   = !disp_req && w_clear;
    assign w_head     = r_fifo[r_rp];
    assign w_level_nx = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);

`ifdef FB_CLEAR_EN
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [9:0] X_LAST  = 10'(FRAME_W - 1);
    localparam logic [8:0] Y_LAST  = 9'(FRAME_H - 1);
    logic [0:0] r_state;
    logic [9:0] r_cx;
    logic [8:0] r_cy;
    logic       w_clr_done;

    assign w_clear    = r_state == S_CLEAR;
    assign w_clr_done = w_clr_wr && r_cx == X_LAST && r_cy == Y_LAST;
    assign w_clear_nx = w_clear ? !w_clr_done : clear_start;
    assign w_clr_x    = r_cx;
    assign w_clr_y    = r_cy;
    assign clear_busy = w_clear;

    // The clear cursor only advances on cycles the display leaves free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
        end else if (!w_clear) begin
            r_state <= clear_start ? S_CLEAR : S_IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
        end else if (w_clr_wr) begin
            r_state <= w_clr_done ? S_IDLE : S_CLEAR;
            r_cx    <= r_cx == X_LAST ? '0 : r_cx + 10'd1;
            r_cy    <= r_cx == X_LAST ? r_cy + 9'd1 : r_cy;
        end
    end
`else
    assign w_clear    = 1'b0;
    assign w_clear_nx = 1'b0;
    assign w_clr_x    = '0;
    assign w_clr_y    = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_level     <= '0;
            r_wr_ready  <= 1'b0;
            r_drop      <= '0;
            r_stall     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_x     <= '0;
            r_mem_y     <= '0;
            r_mem_wdata <= '0;
            r_rsh       <= '0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_wp       <= r_wp + AW'(w_push);
            r_rp       <= r_rp + AW'(w_pop);
            r_level    <= w_level_nx;
            r_wr_ready <= w_level_nx != (AW+1)'(WFIFO_DEPTH) && !w_clear_nx;
            if (w_drop && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;
            r_stall  <= disp_req && r_level != '0;
            r_mem_we <= w_clr_wr || w_pop;
            if (disp_req) begin
                r_mem_x <= disp_x;
                r_mem_y <= disp_y;
            end else if (w_clr_wr) begin
                r_mem_x     <= w_clr_x;
                r_mem_y     <= w_clr_y;
                r_mem_wdata <= '0;
            end else if (w_pop) begin
                {r_mem_x, r_mem_y, r_mem_wdata} <= w_head;
            end
            // Last shift stage lines up with douta being valid for that request
            r_rsh    <= (r_rsh << 1) | READ_LATENCY'(disp_req);
            r_rvalid <= r_rsh[READ_LATENCY-1];
            if (r_rsh[READ_LATENCY-1])
                r_rdata <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wp] <= {wr_x, wr_y, wr_data};
    end

    assign wr_ready    = r_wr_ready;
    assign disp_rvalid = r_rvalid;
    assign disp_rdata  = r_rdata;
    assign mem_x       = r_mem_x;
    assign mem_y       = r_mem_y;
    assign mem_we      = r_mem_we;
    assign mem_wdata   = r_mem_wdata;
    assign fifo_level  = r_level;
    assign drop_count  = r_drop;
    assign write_stall = r_stall;
endmodule

// File: tb/tb_frame_port_arbiter.sv
// tb_frame_port_arbiter: directed checks of the frame memory arbiter with READ_LATENCY 1 and 3 instances on shared stimulus
module tb_frame_port_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid, disp_req;
    logic [9:0] wr_x, disp_x;
    logic [8:0] wr_y, disp_y;
    logic [2:0] wr_data;

    logic       wr_ready, a_rvalid, m1_we, stall1;
    logic [2:0] a_rdata, m1_wd, m1_rd;
    logic [9:0] m1_x;
    logic [8:0] m1_y;
    logic [2:0] level1;
    logic [15:0] drop1;

    logic       wr_ready3, b_rvalid, m3_we, stall3;
    logic [2:0] b_rdata, m3_wd, m3_rd, p3a, p3b;
    logic [9:0] m3_x;
    logic [8:0] m3_y;
    logic [2:0] level3;
    logic [15:0] drop3;

    logic [2:0] mem1 [0:524287];
    logic [2:0] mem3 [0:524287];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frame_port_arbiter u_dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .disp_req(disp_req),
        .disp_x(disp_x), .disp_y(disp_y), .disp_rvalid(a_rvalid), .disp_rdata(a_rdata),
        .mem_x(m1_x), .mem_y(m1_y), .mem_we(m1_we), .mem_wdata(m1_wd), .mem_rdata(m1_rd),
        .fifo_level(level1), .drop_count(drop1), .write_stall(stall1)
    );

    frame_port_arbiter #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready3),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .disp_req(disp_req),
        .disp_x(disp_x), .disp_y(disp_y), .disp_rvalid(b_rvalid), .disp_rdata(b_rdata),
        .mem_x(m3_x), .mem_y(m3_y), .mem_we(m3_we), .mem_wdata(m3_wd), .mem_rdata(m3_rd),
        .fifo_level(level3), .drop_count(drop3), .write_stall(stall3)
    );

    // Memory models: latency 1 reads the registered address directly, latency 3 adds two output registers
    always @(posedge clk) begin
        if (m1_we) mem1[{m1_x, m1_y}] <= m1_wd;
        if (m3_we) mem3[{m3_x, m3_y}] <= m3_wd;
        p3a <= mem3[{m3_x, m3_y}];
        p3b <= p3a;
    end
    assign m1_rd = mem1[{m1_x, m1_y}];
    assign m3_rd = p3b;

    wire [22:0] w_bus  = {m1_we, m1_x, m1_y, m1_wd};
    wire [47:0] w_all  = {wr_ready, a_rvalid, a_rdata, m1_we, m1_x, m1_y, m1_wd, level1, drop1, stall1};
    wire [47:0] w_all3 = {wr_ready3, b_rvalid, b_rdata, m3_we, m3_x, m3_y, m3_wd, level3, drop3, stall3};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int x, input int y, input int d);
        wr_valid = 1'b1;
        wr_x     = 10'(x);
        wr_y     = 9'(y);
        wr_data  = 3'(d);
    endtask

    function automatic logic [22:0] bus(input logic we, input int x, input int y, input int d);
        return {we, 10'(x), 9'(y), 3'(d)};
    endfunction

    initial begin
        int   k;
        logic rdy;
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_data = 0;
        disp_req = 0; disp_x = 0; disp_y = 0;
        tick; tick;
        check("reset_outputs", w_all, 0);
        check("reset_outputs_rl3", w_all3, 0);
        rst = 1'b0;
        #1;
        check("ready_at_release", wr_ready, 0);
        tick;
        check("ready_after_release", wr_ready, 1);

        put(10, 5, 1); tick;
        check("w_level_1", level1, 1);
        check("w_idle_first", m1_we, 0);
        put(11, 5, 2); tick;
        check("w_first", w_bus, bus(1, 10, 5, 1));
        put(12, 5, 3); tick;
        check("w_second", w_bus, bus(1, 11, 5, 2));
        wr_valid = 0; tick;
        check("w_third", w_bus, bus(1, 12, 5, 3));
        tick;
        check("w_done_we", m1_we, 0);
        check("w_done_level", level1, 0);

        disp_req = 1; disp_x = 0; disp_y = 0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            put(20 + k, 7, k + 1);
            rdy = wr_ready;
            tick;
            if (rdy) k++;
            if (c > 0) check("starve_stall", stall1, 1);
            check("starve_no_we", m1_we, 0);
        end
        check("starve_accepted", k, 4);
        check("starve_level", level1, 4);
        check("starve_ready", wr_ready, 0);
        disp_req = 0; wr_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("drain", w_bus, bus(1, 20 + i, 7, i + 1));
        end
        check("drain_ready", wr_ready, 1);
        tick;
        check("drain_end_we", m1_we, 0);
        check("drain_end_level", level1, 0);

        put(640, 0, 7); tick;
        put(0, 480, 7); tick;
        wr_valid = 0;
        check("drop_count", drop1, 2);
        check("drop_level", level1, 0);
        check("drop_ready", wr_ready, 1);
        check("drop_no_we", m1_we, 0);
        tick;
        check("drop_no_we_late", m1_we, 0);

        put(100, 200, 5); tick;
        wr_valid = 0; tick;
        check("rd_setup_write", w_bus, bus(1, 100, 200, 5));
        tick;
        disp_req = 1; disp_x = 100; disp_y = 200;
        tick;
        disp_req = 0;
        check("rd_n1_rl1", a_rvalid, 0);
        tick;
        check("rd_n2_rl1_valid", a_rvalid, 1);
        check("rd_n2_rl1_data", a_rdata, 5);
        check("rd_n2_rl3", b_rvalid, 0);
        tick;
        check("rd_n3_rl1", a_rvalid, 0);
        check("rd_n3_rl3", b_rvalid, 0);
        tick;
        check("rd_n4_rl3_valid", b_rvalid, 1);
        check("rd_n4_rl3_data", b_rdata, 5);
        tick;
        check("rd_n5_rl3", b_rvalid, 0);

        put(100, 200, 6); tick;
        wr_valid = 0; disp_req = 1; tick;
        check("order_stall", stall1, 1);
        check("order_no_we", m1_we, 0);
        disp_req = 0; tick;
        check("order_old_valid", a_rvalid, 1);
        check("order_old_data", a_rdata, 5);
        check("order_write", w_bus, bus(1, 100, 200, 6));
        tick;
        disp_req = 1; tick;
        disp_req = 0; tick;
        check("order_new_data", {a_rvalid, a_rdata}, {1'b1, 3'd6});

        disp_req = 1; disp_x = 3; disp_y = 3;
        put(1, 1, 1); tick;
        put(2, 2, 2); tick;
        wr_valid = 0;
        check("mid_level", level1, 2);
        rst = 1; disp_req = 0;
        #1;
        check("mid_reset_all", w_all, 0);
        check("mid_reset_all_rl3", w_all3, 0);
        tick;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("mid_no_stale_rvalid", {a_rvalid, b_rvalid}, 0);
        end
        check("mid_after_level", level1, 0);
        check("mid_after_ready", wr_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/frame_port_arbiter.md
Name: frame_port_arbiter

Overview:
- Shares the single-port frame cell memory (3-bit pixels, address = {x[9:0], y[8:0]}) between two requesters:
  - the pixel writer (rasterizer side)
  - the display scan reader (VGA side)
- Display reads have strict priority. Writes are buffered in a small FIFO and drained into idle memory cycles.
- Sits between the rasterizer/VGA timing logic and the frame cell memory. Drives the memory's address, write-enable and write-data pins directly from registers.

Parameters:
- WFIFO_DEPTH, 4, write FIFO entries; power of 2, 2..16.
- READ_LATENCY, 1, memory clocks from registered address to valid douta; 1..3.
- FRAME_W, 640, visible width; writes with x >= FRAME_W are dropped.
- FRAME_H, 480, visible height; writes with y >= FRAME_H are dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wr_valid  in  1  writer has a pixel
- wr_ready  out  1  FIFO can accept; equals !full
- wr_x  in  10  writer x
- wr_y  in  9  writer y
- wr_data  in  3  writer pixel value
- disp_req  in  1  display read request this cycle
- disp_x  in  10  display x
- disp_y  in  9  display y
- disp_rvalid  out  1  disp_rdata valid
- disp_rdata  out  3  read pixel
- mem_x  out  10  memory address high part (registered)
- mem_y  out  9  memory address low part (registered)
- mem_we  out  1  memory write enable (registered)
- mem_wdata  out  3  memory write data (registered)
- mem_rdata  in  3  memory douta
- fifo_level  out  log2(WFIFO_DEPTH)+1  current FIFO occupancy
- drop_count  out  16  saturating count of out-of-range writes
- write_stall  out  1  pulse: FIFO non-empty but slot taken by display

Behaviour:
- Reset (async, rst=1): all of the following are 0; FIFO pointers are cleared.
  - wr_ready, disp_rvalid, disp_rdata
  - mem_x, mem_y, mem_we, mem_wdata
  - fifo_level, drop_count, write_stall
- wr_ready rises 1 cycle after rst deasserts.
- Reset mid-operation discards FIFO contents and in-flight reads; no disp_rvalid is produced for requests issued before reset.
- Write accept: handshake when wr_valid && wr_ready.
  - If wr_x >= FRAME_W or wr_y >= FRAME_H: the pixel is consumed but not stored, and drop_count increments (saturates at 16'hFFFF).
  - Otherwise the pixel is pushed to the FIFO.
  - wr_ready is computed from the registered full flag only. A pop in the same cycle does not enable a push when full.
- Arbitration, evaluated each cycle, result registered onto mem_* at the next edge:
  - disp_req=1: read slot. mem_we<=0, mem_x/mem_y<=disp_x/disp_y. If the FIFO is non-empty, write_stall<=1.
  - disp_req=0 and FIFO non-empty: write slot. Pop the head; mem_we<=1; mem_x/mem_y/mem_wdata<=entry.
  - Otherwise: mem_we<=0, and address/wdata hold their previous values.
- A push and a pop in the same cycle leave fifo_level unchanged.
- Read return:
  - disp_req is delayed through a 1+READ_LATENCY stage shift register that drives disp_rvalid.
  - disp_rdata is registered mem_rdata, captured in the cycle the delayed valid asserts.
  - Total latency: disp_req at cycle N gives disp_rvalid at N+1+READ_LATENCY (N+2 at default).
- Back-to-back disp_req every cycle is supported at full throughput; writes starve for the duration, which is intentional (display timing owns the memory).
- Ordering: writes reach memory in FIFO (acceptance) order. A read issued in the same cycle a write to the same address is still queued returns the old value.

Optional Feature:
- Macro FB_CLEAR_EN.
- Defined: adds ports clear_start (in, 1) and clear_busy (out, 1), plus a state machine IDLE -> CLEAR -> IDLE.
  - A clear_start pulse in IDLE enters CLEAR and sets clear_busy=1, with an internal x/y counter from (0,0).
  - CLEAR behaviour:
    - Each cycle without disp_req writes 0 to (x,y), then advances x; on x wrap at FRAME_W-1, x resets to 0 and y advances.
    - After (FRAME_W-1, FRAME_H-1) is written, returns to IDLE and drops clear_busy.
    - wr_ready is forced 0; FIFO contents are held until the clear completes, then drained.
    - Display reads keep priority.
  - clear_start while busy is ignored. Reset returns to IDLE with clear_busy=0.
- Undefined: no clear ports, no clear state; the behaviour is exactly as above.

Test Plan:
- Reset then 3 writes (10,5,3'd1),(11,5,3'd2),(12,5,3'd3) with disp_req=0 -> mem_we high on 3 consecutive cycles starting 2 cycles after the first accept, addresses/data in order.
- disp_req held 8 cycles while 4 writes are offered -> FIFO fills to 4, wr_ready=0 on the 5th, write_stall=1 each cycle, no mem_we; after disp_req drops, 4 writes drain in 4 cycles.
- Write (640,0,3'd7) and (0,480,3'd7) -> both accepted, never reach the FIFO, drop_count=2, mem_we stays 0.
- Write (100,200,3'd5), drain, then disp_req at (100,200) at cycle N -> disp_rvalid at N+2 with disp_rdata=5; the test is repeated with READ_LATENCY=3, giving N+4.
- FIFO half full, rst pulsed mid-stream -> all outputs 0 immediately; fifo_level=0; no disp_rvalid for pre-reset requests.
- FB_CLEAR_EN: clear_start with disp_req=0 -> clear_busy high for exactly 307200 cycles, memory all zeros afterward; with disp_req at 50% duty, the clear takes 614400 cycles.
